// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: FSM encoding, default depth and entry layout.
package store_buffer_pkg;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_e;

  localparam int SB_DEPTH_DEFAULT      = 4;
  localparam int SB_WIDTH_DEFAULT      = 32;
  localparam int SB_ADDR_WIDTH_DEFAULT = 32;

  // One buffered store at the default widths; the top keeps the same
  // {addr, data} pairing in per-field arrays sized by its parameters.
  typedef struct packed {
    logic [SB_ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [SB_WIDTH_DEFAULT-1:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/sb_forward.sv
// Youngest-match search over the buffered stores for load forwarding.
module sb_forward
  import store_buffer_pkg::*;
#(
  parameter int width     = 32,
  parameter int AddrWidth = 32,
  parameter int depth     = SB_DEPTH_DEFAULT,
  localparam int PtrW     = $clog2(depth)
) (
  input  logic [depth-1:0]     valid,
  input  logic [PtrW-1:0]      head,
  input  logic [AddrWidth-3:0] words [depth],
  input  logic [width-1:0]     datas [depth],
  input  logic [AddrWidth-3:0] ld_word,
  output logic                 hit,
  output logic [width-1:0]     data
);

  logic [PtrW-1:0] slot;

  // Walk from oldest (head) to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int i = 0; i < depth; i++) begin
      slot = head + PtrW'(i);
      if (valid[slot] && (words[slot] == ld_word)) begin
        hit  = 1'b1;
        data = datas[slot];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store path and data memory, with load
// forwarding and a flush handshake that drains everything before a halt.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int width     = 32,
  parameter int AddrWidth = 32,
  parameter int depth     = SB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AddrWidth-1:0]     st_addr,
  input  logic [width-1:0]         st_data,
  input  logic [AddrWidth-1:0]     ld_addr,
  output logic                     ld_hit,
  output logic [width-1:0]         ld_data,
  input  logic                     mem_hold,
  output logic                     mem_write,
  output logic [AddrWidth-1:0]     mem_addr,
  output logic [width-1:0]         mem_wdata,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic [$clog2(depth):0]   count
);

  localparam int PtrW = $clog2(depth);
  localparam int CntW = PtrW + 1;

  logic [AddrWidth-1:0] addr_q [depth];
  logic [width-1:0]     data_q [depth];
  logic [AddrWidth-3:0] word_q [depth];
  logic [PtrW-1:0]      head, tail, offset;
  logic [depth-1:0]     valid;
  logic                 full, push, pop;
  logic                 flush_done_next;
  sb_state_e            state, state_next;
  logic                 unused_ld_low;

  // Byte offset within the word plays no part in forwarding.
  assign unused_ld_low = ^ld_addr[1:0];

  // Handshake and drain port: full blocks a push even if a pop frees a slot this cycle.
  always_comb begin
    full      = (count == CntW'(depth));
    st_ready  = !full && (state == SB_RUN);
    push      = st_valid && st_ready;
    pop       = (count != '0) && !mem_hold;
    mem_write = pop;
    mem_addr  = addr_q[head];
    mem_wdata = data_q[head];
  end

  // Slot is live when its distance from head is below count; strip byte bits for the compare.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < depth; i++) begin
      offset    = PtrW'(i) - head;
      valid[i]  = ({1'b0, offset} < count);
      word_q[i] = addr_q[i][AddrWidth-1:2];
    end
  end

  sb_forward #(
    .width    (width),
    .AddrWidth(AddrWidth),
    .depth    (depth)
  ) u_forward (
    .valid  (valid),
    .head   (head),
    .words  (word_q),
    .datas  (data_q),
    .ld_word(ld_addr[AddrWidth-1:2]),
    .hit    (ld_hit),
    .data   (ld_data)
  );

  // Flush FSM: leave FLUSH once empty and announce completion one cycle later.
  always_comb begin
    state_next      = state;
    flush_done_next = 1'b0;
    case (state)
      SB_RUN:   if (flush_req) state_next = SB_FLUSH;
      SB_FLUSH: if (count == '0) begin
        state_next      = SB_RUN;
        flush_done_next = 1'b1;
      end
      default:  state_next = SB_RUN;
    endcase
  end

  // Control state: pointers, occupancy, FSM and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SB_RUN;
      flush_done <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      flush_done <= flush_done_next;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; occupancy alone says which slots mean anything.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_store_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_hold = 1'b0;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  store_buffer #(.width(32), .AddrWidth(32), .depth(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_hold(mem_hold), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush_req(flush_req), .flush_done(flush_done), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    cyc();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    st_valid = 1'b0; mem_hold = 1'b0; flush_req = 1'b0;
    repeat (2 * D) cyc();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld got %b/%h exp 0/0", ld_hit, ld_data); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
  endtask

  task automatic test_single_store();
    cyc();
    push(32'h10, 32'hA5A5A5A5);
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL single_write got %b exp 1", mem_write); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL single_addr got %h exp 10", mem_addr); end
    checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_data got %h exp a5a5a5a5", mem_wdata); end
    cyc();
    @(negedge clk);
    checks++; if (count !== 3'd0 || mem_write !== 1'b0) begin errors++; $display("FAIL single_empty got %0d/%b exp 0/0", count, mem_write); end
  endtask

  task automatic test_hold_full();
    cyc();
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'hC0DE0000 + 32'(i));
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", st_ready); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL full_hold_write got %b exp 0", mem_write); end
    cyc();
    st_valid = 1'b0; mem_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (mem_write !== 1'b1 || mem_addr !== 32'(i * 4) || mem_wdata !== 32'hC0DE0000 + 32'(i)) begin
        errors++; $display("FAIL full_drain%0d got %b %h %h exp 1 %h %h", i, mem_write, mem_addr, mem_wdata, 32'(i * 4), 32'hC0DE0000 + 32'(i));
      end
      checks++; if (st_ready !== (i != 0)) begin errors++; $display("FAIL full_drain_ready%0d got %b exp %b", i, st_ready, i != 0); end
      cyc();
    end
    @(negedge clk);
    checks++; if (count !== 3'd0 || mem_write !== 1'b0) begin errors++; $display("FAIL full_after got %0d/%b exp 0/0", count, mem_write); end
  endtask

  task automatic test_forwarding();
    cyc();
    mem_hold = 1'b1;
    push(32'h30, 32'd7);
    push(32'h20, 32'd1);
    push(32'h20, 32'd2);
    ld_addr = 32'h22;
    @(negedge clk);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd2) begin errors++; $display("FAIL fwd_youngest got %b/%h exp 1/2", ld_hit, ld_data); end
    ld_addr = 32'h24;
    #1;
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin errors++; $display("FAIL fwd_miss got %b/%h exp 0/0", ld_hit, ld_data); end
    st_valid = 1'b1; st_addr = 32'h24; st_data = 32'd9;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %b exp 0", ld_hit); end
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin errors++; $display("FAIL fwd_next_cycle got %b/%h exp 1/9", ld_hit, ld_data); end
    ld_addr = 32'h31;
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd7) begin errors++; $display("FAIL fwd_oldest got %b/%h exp 1/7", ld_hit, ld_data); end
    cyc();
    drain();
    @(negedge clk);
    checks++; if (count !== 3'd0 || ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got %0d/%b exp 0/0", count, ld_hit); end
  endtask

  task automatic test_back_to_back();
    ent_t exp[$];
    ent_t e;
    cyc();
    mem_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e.addr = 32'h80 + 32'(i * 4); e.data = $urandom;
      exp.push_back(e);
      push(e.addr, e.data);
    end
    mem_hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      e.addr = 32'h40 + 32'(k * 4); e.data = $urandom;
      st_valid = 1'b1; st_addr = e.addr; st_data = e.data;
      @(negedge clk);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got %0d exp 2", k, count); end
      checks++; if (mem_write !== 1'b1 || mem_addr !== exp[0].addr || mem_wdata !== exp[0].data) begin
        errors++; $display("FAIL b2b_order%0d got %b %h %h exp 1 %h %h", k, mem_write, mem_addr, mem_wdata, exp[0].addr, exp[0].data);
      end
      void'(exp.pop_front());
      exp.push_back(e);
      cyc();
    end
    st_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (mem_write !== 1'b1 || mem_addr !== exp[0].addr || mem_wdata !== exp[0].data) begin
        errors++; $display("FAIL b2b_tail%0d got %b %h %h exp 1 %h %h", k, mem_write, mem_addr, mem_wdata, exp[0].addr, exp[0].data);
      end
      void'(exp.pop_front());
      cyc();
    end
    @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    int writes, pulses, bad_ready, done_k;
    cyc();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i * 4), 32'(i));
    mem_hold = 1'b0; flush_req = 1'b1;
    writes = 0; pulses = 0; bad_ready = 0; done_k = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_write) writes++;
      if (flush_done) pulses++;
      if (flush_done && done_k < 0) done_k = k;
      if (k >= 1 && done_k < 0 && st_ready) bad_ready++;
      cyc();
      flush_req = 1'b0;
    end
    checks++; if (writes != 3) begin errors++; $display("FAIL flush_writes got %0d exp 3", writes); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL flush_pulses got %0d exp 1", pulses); end
    checks++; if (done_k < 0) begin errors++; $display("FAIL flush_timeout got %0d exp >=0", done_k); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL flush_ready_blocked got %0d exp 0", bad_ready); end
    @(negedge clk);
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b exp 1", st_ready); end
  endtask

  task automatic test_flush_empty();
    int pulses, done_k;
    cyc();
    flush_req = 1'b1;
    pulses = 0; done_k = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (flush_done) pulses++;
      if (flush_done && done_k < 0) done_k = k;
      cyc();
      flush_req = 1'b0;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL flush_empty_pulses got %0d exp 1", pulses); end
    checks++; if (done_k < 1 || done_k > 2) begin errors++; $display("FAIL flush_empty_latency got %0d exp 1..2", done_k); end
  endtask

  task automatic test_random();
    logic        exp_ready, exp_write, exp_hit;
    logic [31:0] exp_data;
    q.delete();
    cyc();
    for (int n = 0; n < 400; n++) begin
      st_valid = ($urandom_range(0, 9) < 6);
      st_addr  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      st_data  = $urandom;
      mem_hold = ($urandom_range(0, 3) == 0);
      ld_addr  = (32'($urandom_range(0, 8)) << 2) | 32'($urandom_range(0, 3));
      @(negedge clk);
      exp_ready = (q.size() < D);
      exp_write = (q.size() != 0) && !mem_hold;
      exp_hit = 1'b0; exp_data = '0;
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].addr[31:2] == ld_addr[31:2]) begin
          exp_hit = 1'b1; exp_data = q[j].data;
          break;
        end
      end
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count@%0d got %0d exp %0d", n, count, q.size()); end
      checks++; if (st_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d got %b exp %b", n, st_ready, exp_ready); end
      checks++; if (mem_write !== exp_write) begin errors++; $display("FAIL rnd_write@%0d got %b exp %b", n, mem_write, exp_write); end
      checks++; if (ld_hit !== exp_hit || ld_data !== exp_data) begin errors++; $display("FAIL rnd_fwd@%0d got %b/%h exp %b/%h", n, ld_hit, ld_data, exp_hit, exp_data); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rnd_flush_done@%0d got %b exp 0", n, flush_done); end
      if (exp_write) begin
        checks++; if (mem_addr !== q[0].addr || mem_wdata !== q[0].data) begin
          errors++; $display("FAIL rnd_drain@%0d got %h/%h exp %h/%h", n, mem_addr, mem_wdata, q[0].addr, q[0].data);
        end
        void'(q.pop_front());
      end
      if (st_valid && exp_ready) q.push_back('{addr: st_addr, data: st_data});
      cyc();
    end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    cyc();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i * 4), 32'hF00 + 32'(i));
    mem_hold = 1'b0;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rmd_writing got %b exp 1", mem_write); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rmd_write_async got %b exp 0", mem_write); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmd_count_async got %0d exp 0", count); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (count !== 3'd0 || st_ready !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL rmd_after got %0d/%b/%b exp 0/1/0", count, st_ready, mem_write);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_hold_full();
    test_forwarding();
    test_back_to_back();
    test_flush();
    test_flush_empty();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
